// File: rtl/boreal_ledger_pkg.sv
// Shared constants and FSM state encoding for the boreal chain ledger.
// FNV-1a 64-bit parameters plus the IDLE/HASH/COMMIT state constants.
package boreal_ledger_pkg;

    localparam logic [63:0] FNV_OFFSET = 64'hCBF29CE484222325;
    localparam logic [63:0] FNV_PRIME  = 64'h00000100000001B3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_HASH   = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;

endpackage

// File: rtl/boreal_fnv64_step.sv
// One FNV-1a 64-bit round: xor in one byte, multiply by the prime mod 2^64.
module boreal_fnv64_step
    import boreal_ledger_pkg::*;
(
    input  logic [63:0] h_in,
    input  logic [7:0]  byte_in,
    output logic [63:0] h_out
);

    // Single combinational byte step; the product is truncated to 64 bits.
    always_comb begin
        h_out = (h_in ^ {56'd0, byte_in}) * FNV_PRIME;
    end

endmodule

// File: rtl/boreal_chain_ledger.sv
// Append-only hash-chained ledger. Each accepted payload is stored as
// {prev_hash, payload}; the entry is hashed with FNV-1a 64 one byte per
// cycle and then committed, advancing head_hash and count.
// Optional feature: define BOREAL_LEDGER_SEAL_EN to add the seal/sealed
// ports, which permanently close the ledger to further appends.
module boreal_chain_ledger
    import boreal_ledger_pkg::*;
#(
    parameter int  DEPTH     = 1024,
    parameter int  PAYLOAD_W = 192,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int ENTRY_W   = PAYLOAD_W + 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 rd_req,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [ENTRY_W-1:0]   rd_data,
    output logic                 rd_valid,
    output logic                 rd_err,
    output logic [ADDR_W:0]      count,
    output logic [63:0]          head_hash,
    output logic                 busy,
    output logic                 full,
    output logic                 ovf
`ifdef BOREAL_LEDGER_SEAL_EN
    ,
    input  logic                 seal,
    output logic                 sealed
`endif
);

    localparam int NBYTES = ENTRY_W / 8;
    localparam int CNT_W  = $clog2(NBYTES);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [ADDR_W:0]  DEPTH_C   = (ADDR_W + 1)'(DEPTH);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [63:0]          head_hash_q, head_hash_d;
    logic                 ovf_q, ovf_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_err_q, rd_err_d;
    logic [ENTRY_W-1:0]   rd_data_q, rd_data_d;

    logic [ENTRY_W-1:0]   entry_q, entry_d;
    logic [ENTRY_W-1:0]   shift_q, shift_d;
    logic [63:0]          hash_q, hash_d;
    logic [63:0]          step_h;

    logic [ENTRY_W-1:0]   mem_q [DEPTH];

    logic                 sealed_int;
    logic                 full_int;
    logic                 fire;

    assign full_int  = (count_q == DEPTH_C);
    assign in_ready  = (state_q == ST_IDLE) && !full_int && !sealed_int;
    assign fire      = in_valid && in_ready;

    assign count     = count_q;
    assign head_hash = head_hash_q;
    assign busy      = (state_q == ST_HASH) || (state_q == ST_COMMIT);
    assign full      = full_int;
    assign ovf       = ovf_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign rd_data   = rd_data_q;

    // The working byte is always the low byte of a right-shifting copy.
    boreal_fnv64_step u_step (
        .h_in    (hash_q),
        .byte_in (shift_q[7:0]),
        .h_out   (step_h)
    );

    // Next-state logic for the append FSM, overflow flag and read port.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        count_d     = count_q;
        head_hash_d = head_hash_q;
        ovf_d       = ovf_q;
        entry_d     = entry_q;
        shift_d     = shift_q;
        hash_d      = hash_q;
        rd_valid_d  = rd_req;
        rd_err_d    = rd_err_q;
        rd_data_d   = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    entry_d    = {head_hash_q, in_payload};
                    shift_d    = {head_hash_q, in_payload};
                    hash_d     = FNV_OFFSET;
                    byte_cnt_d = '0;
                    state_d    = ST_HASH;
                end
            end
            ST_HASH: begin
                hash_d     = step_h;
                shift_d    = shift_q >> 8;
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                if (byte_cnt_q == LAST_BYTE) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                head_hash_d = hash_q;
                count_d     = count_q + (ADDR_W + 1)'(1);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An append attempt that cannot be honoured is remembered until reset.
        if (in_valid && (full_int || sealed_int)) begin
            ovf_d = 1'b1;
        end

        // Reads use the pre-commit count, so the slot being written this
        // cycle is still reported as out of range.
        if (rd_req) begin
            if ({1'b0, rd_addr} < count_q) begin
                rd_data_d = mem_q[rd_addr];
                rd_err_d  = 1'b0;
            end else begin
                rd_data_d = '0;
                rd_err_d  = 1'b1;
            end
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            count_q     <= '0;
            head_hash_q <= FNV_OFFSET;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            count_q     <= count_d;
            head_hash_q <= head_hash_d;
            ovf_q       <= ovf_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Entry datapath and ledger storage; storage survives reset on purpose.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
        shift_q <= shift_d;
        hash_q  <= hash_d;
        if (state_q == ST_COMMIT) begin
            mem_q[count_q[ADDR_W-1:0]] <= entry_q;
        end
    end

`ifdef BOREAL_LEDGER_SEAL_EN
    logic sealed_q, sealed_d;
    logic seal_pend_q, seal_pend_d;

    assign sealed_int = sealed_q;
    assign sealed     = sealed_q;

    // A seal arriving while an entry is in flight (or being accepted) waits
    // for that entry's commit so the chain is never left half-appended.
    always_comb begin
        sealed_d    = sealed_q;
        seal_pend_d = seal_pend_q;
        if (!sealed_q) begin
            if ((state_q == ST_IDLE) && seal && !fire) begin
                sealed_d = 1'b1;
            end else if ((state_q == ST_COMMIT) && (seal || seal_pend_q)) begin
                sealed_d    = 1'b1;
                seal_pend_d = 1'b0;
            end else if (seal) begin
                seal_pend_d = 1'b1;
            end
        end
    end

    // Sticky seal state, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sealed_q    <= 1'b0;
            seal_pend_q <= 1'b0;
        end else begin
            sealed_q    <= sealed_d;
            seal_pend_q <= seal_pend_d;
        end
    end
`else
    assign sealed_int = 1'b0;
`endif

endmodule

// File: tb/tb_boreal_chain_ledger.sv
// Self-checking bench for boreal_chain_ledger (DEPTH=4, PAYLOAD_W=192).
// Seal scenario is included when BOREAL_LEDGER_SEAL_EN is defined.
module tb_boreal_chain_ledger;

    localparam int DEPTH     = 4;
    localparam int PAYLOAD_W = 192;
    localparam int ADDR_W    = 2;
    localparam int ENTRY_W   = 256;
    localparam int NBYTES    = 32;
    localparam logic [63:0] OFFSET = 64'hCBF29CE484222325;
    localparam logic [63:0] PRIME  = 64'h00000100000001B3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload = '0;
    logic                 rd_req = 1'b0;
    logic [ADDR_W-1:0]    rd_addr = '0;
    logic [ENTRY_W-1:0]   rd_data;
    logic                 rd_valid;
    logic                 rd_err;
    logic [ADDR_W:0]      count;
    logic [63:0]          head_hash;
    logic                 busy;
    logic                 full;
    logic                 ovf;
`ifdef BOREAL_LEDGER_SEAL_EN
    logic                 seal = 1'b0;
    logic                 sealed;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [ENTRY_W-1:0] m_mem[$];
    logic [63:0]        m_head;

    boreal_chain_ledger #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_payload (in_payload),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err),
        .count      (count),
        .head_hash  (head_hash),
        .busy       (busy),
        .full       (full),
        .ovf        (ovf)
`ifdef BOREAL_LEDGER_SEAL_EN
        ,
        .seal       (seal),
        .sealed     (sealed)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference hash: FNV-1a 64 over the entry bytes, least significant first.
    function automatic logic [63:0] fnv(input logic [ENTRY_W-1:0] e);
        logic [63:0]        h;
        logic [ENTRY_W-1:0] t;
        h = OFFSET;
        t = e;
        for (int k = 0; k < NBYTES; k++) begin
            h = (h ^ {56'd0, t[7:0]}) * PRIME;
            t = t >> 8;
        end
        return h;
    endfunction

    function automatic logic [PAYLOAD_W-1:0] rand_pl();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_append(input logic [PAYLOAD_W-1:0] p);
        logic [ENTRY_W-1:0] e;
        e = {m_head, p};
        m_mem.push_back(e);
        m_head = fnv(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        rd_req   = 1'b0;
`ifdef BOREAL_LEDGER_SEAL_EN
        seal     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_mem.delete();
        m_head = OFFSET;
    endtask

    // Presents one payload for a single cycle starting at a falling edge.
    task automatic accept_one(input logic [PAYLOAD_W-1:0] p);
        @(negedge clk);
        in_valid   = 1'b1;
        in_payload = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_append(p);
    endtask

    task automatic wait_not_busy(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {255'd0, busy}, '0);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [ENTRY_W-1:0] d,
                           output logic e, output logic v);
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_req = 1'b0;
        d = rd_data;
        e = rd_err;
        v = rd_valid;
    endtask

    initial begin
        logic [ENTRY_W-1:0]   d;
        logic                 e;
        logic                 v;
        logic [PAYLOAD_W-1:0] p [3];
        int                   n;
        int                   t_acc;
        int                   t_prev;
        logic [63:0]          prev_exp;

        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_count", ENTRY_W'(count), '0);
        chk("rst_head", ENTRY_W'(head_hash), ENTRY_W'(OFFSET));
        chk("rst_in_ready", ENTRY_W'(in_ready), 1);
        chk("rst_ovf", ENTRY_W'(ovf), '0);
        chk("rst_busy", ENTRY_W'(busy), '0);
        chk("rst_full", ENTRY_W'(full), '0);
        chk("rst_rd_valid", ENTRY_W'(rd_valid), '0);

        // Single append of an all-zero payload
        accept_one('0);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("ready_low_cycles", ENTRY_W'(n), ENTRY_W'(NBYTES + 1));
        chk("zero_count", ENTRY_W'(count), 1);
        do_read(0, d, e, v);
        chk("zero_rd_valid", ENTRY_W'(v), 1);
        chk("zero_rd_err", ENTRY_W'(e), '0);
        chk("zero_rd_data", d, {OFFSET, 192'h0});
        chk("zero_head", ENTRY_W'(head_hash), ENTRY_W'(m_head));

        // Reset in the middle of hashing aborts the entry
        accept_one(rand_pl());
        repeat (5) @(negedge clk);
        chk("midhash_busy", ENTRY_W'(busy), 1);
        do_reset();
        @(negedge clk);
        chk("abort_count", ENTRY_W'(count), '0);
        chk("abort_head", ENTRY_W'(head_hash), ENTRY_W'(OFFSET));
        chk("abort_in_ready", ENTRY_W'(in_ready), 1);
        do_read(0, d, e, v);
        chk("stale_rd_err", ENTRY_W'(e), 1);
        chk("stale_rd_data", d, '0);

        // Three back-to-back appends with in_valid held high
        for (int i = 0; i < 3; i++) p[i] = rand_pl();
        @(negedge clk);
        in_valid   = 1'b1;
        in_payload = p[0];
        t_prev     = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ready", ENTRY_W'(in_ready), 1);
            @(posedge clk);
            #1;
            t_acc = cyc;
            model_append(p[i]);
            if (i > 0) chk("b2b_gap", ENTRY_W'(t_acc - t_prev), ENTRY_W'(NBYTES + 2));
            t_prev = t_acc;
            if (i < 2) in_payload = p[i + 1];
            else in_valid = 1'b0;
        end
        wait_not_busy("b2b_drain");
        chk("b2b_count", ENTRY_W'(count), 3);
        prev_exp = OFFSET;
        for (int a = 0; a < 3; a++) begin
            do_read(ADDR_W'(a), d, e, v);
            chk("b2b_rd_err", ENTRY_W'(e), '0);
            chk("b2b_prev_hash", ENTRY_W'(d[ENTRY_W-1 -: 64]), ENTRY_W'(prev_exp));
            chk("b2b_entry", d, m_mem[a]);
            prev_exp = fnv(m_mem[a]);
        end
        chk("b2b_head", ENTRY_W'(head_hash), ENTRY_W'(m_head));

        // Read at address == count is out of range
        do_read(ADDR_W'(3), d, e, v);
        chk("oor_rd_valid", ENTRY_W'(v), 1);
        chk("oor_rd_err", ENTRY_W'(e), 1);
        chk("oor_rd_data", d, '0);

        // Fill to DEPTH, then attempt one more
        accept_one(rand_pl());
        wait_not_busy("fill_drain");
        chk("fill_full", ENTRY_W'(full), 1);
        chk("fill_in_ready", ENTRY_W'(in_ready), '0);
        chk("fill_count", ENTRY_W'(count), 4);
        chk("fill_ovf_before", ENTRY_W'(ovf), '0);
        @(negedge clk);
        in_valid   = 1'b1;
        in_payload = rand_pl();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("over_ovf", ENTRY_W'(ovf), 1);
        chk("over_busy", ENTRY_W'(busy), '0);
        chk("over_count", ENTRY_W'(count), 4);
        chk("over_head", ENTRY_W'(head_hash), ENTRY_W'(m_head));
        do_read(ADDR_W'(3), d, e, v);
        chk("over_last_entry", d, m_mem[3]);

        // Read sampled in the COMMIT cycle at address count
        do_reset();
        @(negedge clk);
        chk("rst2_ovf", ENTRY_W'(ovf), '0);
        accept_one(rand_pl());
        repeat (NBYTES) @(posedge clk);
        do_read(0, d, e, v);
        chk("commit_rd_valid", ENTRY_W'(v), 1);
        chk("commit_rd_err", ENTRY_W'(e), 1);
        chk("commit_rd_data", d, '0);
        chk("commit_count", ENTRY_W'(count), 1);
        do_read(0, d, e, v);
        chk("post_commit_entry", d, m_mem[0]);
        chk("post_commit_head", ENTRY_W'(head_hash), ENTRY_W'(m_head));

`ifdef BOREAL_LEDGER_SEAL_EN
        // Seal raised during HASH is deferred until the commit lands
        do_reset();
        @(negedge clk);
        chk("seal_rst", ENTRY_W'(sealed), '0);
        accept_one(rand_pl());
        repeat (3) @(negedge clk);
        seal = 1'b1;
        @(negedge clk);
        seal = 1'b0;
        wait_not_busy("seal_drain");
        chk("seal_count", ENTRY_W'(count), 1);
        chk("seal_sealed", ENTRY_W'(sealed), 1);
        chk("seal_head", ENTRY_W'(head_hash), ENTRY_W'(m_head));
        chk("seal_in_ready", ENTRY_W'(in_ready), '0);
        chk("seal_ovf_before", ENTRY_W'(ovf), '0);
        @(negedge clk);
        in_valid   = 1'b1;
        in_payload = rand_pl();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("seal_ovf", ENTRY_W'(ovf), 1);
        chk("seal_count_after", ENTRY_W'(count), 1);
        chk("seal_busy_after", ENTRY_W'(busy), '0);
        chk("seal_head_frozen", ENTRY_W'(head_hash), ENTRY_W'(m_head));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
